// File: rtl/bicubic_phase_gen_if.sv
// bicubic_phase_gen_if: start/config and output-beat bundle of the bicubic phase generator
//   start, src_width, dst_width, step, init_phase : line request and its settings
//   out_ready                                     : downstream accepts the current beat
//   out_valid, x_blend, tap_m1..tap_p2, out_last  : per-pixel beat
//   busy, done                                    : line status
interface bicubic_phase_gen_if #(
    parameter int IDX_W  = 12,
    parameter int FRAC_W = 8
);
    logic              start;
    logic [IDX_W-1:0]  src_width;
    logic [IDX_W-1:0]  dst_width;
    logic [FRAC_W+3:0] step;
    logic [FRAC_W-1:0] init_phase;
    logic              out_ready;
    logic              out_valid;
    logic [8:0]        x_blend;
    logic [IDX_W-1:0]  tap_m1;
    logic [IDX_W-1:0]  tap_0;
    logic [IDX_W-1:0]  tap_p1;
    logic [IDX_W-1:0]  tap_p2;
    logic              out_last;
    logic              busy;
    logic              done;
    modport master (
        output start, src_width, dst_width, step, init_phase, out_ready,
        input  out_valid, x_blend, tap_m1, tap_0, tap_p1, tap_p2, out_last, busy, done
    );
    modport slave (
        input  start, src_width, dst_width, step, init_phase, out_ready,
        output out_valid, x_blend, tap_m1, tap_0, tap_p1, tap_p2, out_last, busy, done
    );
endinterface

// File: rtl/bicubic_phase_gen.sv
// bicubic_phase_gen: per-line source position stepper producing blend fraction and clamped bicubic taps
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bicubic_phase_gen_if slave (line request in, registered output beats out)
module bicubic_phase_gen #(
    parameter int IDX_W  = 12,
    parameter int FRAC_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    bicubic_phase_gen_if.slave bus
);
    localparam int AW = IDX_W + FRAC_W + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state, state_n;
    logic [AW-1:0]     acc, acc_n;
    logic [AW:0]       sum;
    logic [IDX_W-1:0]  cnt, cnt_n, sw, sw_n, dw, dw_n;
    logic [FRAC_W+3:0] stp, stp_n;
    logic              valid, valid_n, last, last_n;
    logic [8:0]        blend, blend_n;
    logic [IDX_W-1:0]  tm1, tm1_n, t0, t0_n, tp1, tp1_n, tp2, tp2_n;
    logic [IDX_W:0]    raw, lim, idx, idx_p1, idx_p2;
    logic              load, clear, in_range;
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        sw_n    = sw;
        dw_n    = dw;
        stp_n   = stp;
        load    = 1'b0;
        clear   = 1'b0;
        sum     = {1'b0, acc} + (AW+1)'(stp);
        case (state)
            IDLE: if (bus.start) begin
                sw_n    = bus.src_width;
                dw_n    = bus.dst_width;
                stp_n   = bus.step;
                acc_n   = AW'(bus.init_phase);
                cnt_n   = '0;
                state_n = (bus.dst_width == '0) ? DONE : RUN;
                load    = (bus.dst_width != '0);
            end
            RUN: if (bus.out_ready) begin
                if (last) begin
                    state_n = DONE;
                    clear   = 1'b1;
                end else begin
                    acc_n = sum[AW] ? '1 : sum[AW-1:0];
                    cnt_n = cnt + IDX_W'(1);
                    load  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // next beat is derived from the post-update accumulator so outputs stay registered
        raw      = acc_n[AW-1:FRAC_W];
        lim      = {1'b0, sw_n} - (IDX_W+1)'(1);
        in_range = raw <= lim;
        idx      = in_range ? raw : lim;
        idx_p1   = idx + (IDX_W+1)'(1);
        idx_p2   = idx + (IDX_W+1)'(2);
        valid_n  = load ? 1'b1 : clear ? 1'b0 : valid;
        blend_n  = load ? (in_range ? 9'(acc_n[FRAC_W-1:0]) : 9'd0) : clear ? 9'd0 : blend;
        t0_n     = load ? idx[IDX_W-1:0] : clear ? '0 : t0;
        tm1_n    = load ? ((idx == '0) ? '0 : idx[IDX_W-1:0] - IDX_W'(1)) : clear ? '0 : tm1;
        tp1_n    = load ? ((idx_p1 > lim) ? lim[IDX_W-1:0] : idx_p1[IDX_W-1:0]) : clear ? '0 : tp1;
        tp2_n    = load ? ((idx_p2 > lim) ? lim[IDX_W-1:0] : idx_p2[IDX_W-1:0]) : clear ? '0 : tp2;
        last_n   = load ? (cnt_n == dw_n - IDX_W'(1)) : clear ? 1'b0 : last;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sw    <= '0;
            dw    <= '0;
            stp   <= '0;
            valid <= 1'b0;
            blend <= '0;
            tm1   <= '0;
            t0    <= '0;
            tp1   <= '0;
            tp2   <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            sw    <= sw_n;
            dw    <= dw_n;
            stp   <= stp_n;
            valid <= valid_n;
            blend <= blend_n;
            tm1   <= tm1_n;
            t0    <= t0_n;
            tp1   <= tp1_n;
            tp2   <= tp2_n;
            last  <= last_n;
        end
    end
    assign bus.out_valid = valid;
    assign bus.x_blend   = blend;
    assign bus.tap_m1    = tm1;
    assign bus.tap_0     = t0;
    assign bus.tap_p1    = tp1;
    assign bus.tap_p2    = tp2;
    assign bus.out_last  = last;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
endmodule

// File: tb/tb_bicubic_phase_gen.sv
// tb_bicubic_phase_gen: directed and randomized line runs checked against an arithmetic position model
module tb_bicubic_phase_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    bicubic_phase_gen_if bus ();
    bicubic_phase_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // source position of beat k is init + k*step, capped at the accumulator maximum
    function automatic void model(input int sw, input int ph, input int stp, input int k,
                                  output int m1, output int z, output int p1, output int p2, output int bl);
        longint pos;
        int raw, lim;
        pos = longint'(ph) + longint'(k) * longint'(stp);
        if (pos > 64'd2097151) pos = 2097151;
        raw = int'(pos / 256);
        lim = sw - 1;
        z   = (raw <= lim) ? raw : lim;
        bl  = (raw <= lim) ? int'(pos % 256) : 0;
        m1  = (z == 0) ? 0 : z - 1;
        p1  = (z + 1 > lim) ? lim : z + 1;
        p2  = (z + 2 > lim) ? lim : z + 2;
    endfunction
    // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready
    task automatic run_line(input int sw, input int dw, input int stp, input int ph,
                            input int mode, input bit poke, input bit abort);
        int k = 0;
        int cyc = 0;
        int m1, z, p1, p2, bl;
        bit rdy;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.src_width  = 12'(sw);
        bus.dst_width  = 12'(dw);
        bus.step       = 12'(stp);
        bus.init_phase = 8'(ph);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.src_width  = 12'($urandom);
        bus.dst_width  = 12'($urandom);
        bus.step       = 12'($urandom);
        bus.init_phase = 8'($urandom);
        if (dw == 0) begin
            chk("empty_valid", 32'(bus.out_valid), 0);
            chk("empty_done", 32'(bus.done), 1);
            @(negedge clk);
            chk("empty_done_end", 32'(bus.done), 0);
            chk("empty_busy_end", 32'(bus.busy), 0);
            return;
        end
        while (k < dw && cyc < 5000) begin
            if (abort && k == 3) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(bus.out_valid), 0);
                chk("rst_tap_0", 32'(bus.tap_0), 0);
                chk("rst_tap_p2", 32'(bus.tap_p2), 0);
                chk("rst_blend", 32'(bus.x_blend), 0);
                chk("rst_last", 32'(bus.out_last), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_done", 32'(bus.done), 0);
                    chk("rst_valid_hold", 32'(bus.out_valid), 0);
                end
                rst_n = 1'b1;
                bus.out_ready = 1'b0;
                return;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            bus.start = poke && cyc == 2;
            model(sw, ph, stp, k, m1, z, p1, p2, bl);
            chk("valid", 32'(bus.out_valid), 1);
            chk("tap_m1", 32'(bus.tap_m1), m1);
            chk("tap_0", 32'(bus.tap_0), z);
            chk("tap_p1", 32'(bus.tap_p1), p1);
            chk("tap_p2", 32'(bus.tap_p2), p2);
            chk("x_blend", 32'(bus.x_blend), bl);
            chk("out_last", 32'(bus.out_last), (k == dw - 1) ? 1 : 0);
            chk("busy_run", 32'(bus.busy), 1);
            chk("done_run", 32'(bus.done), 0);
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        chk("handshakes", k, dw);
        chk("end_valid", 32'(bus.out_valid), 0);
        chk("end_done", 32'(bus.done), 1);
        chk("end_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.src_width = '0;
        bus.dst_width = '0;
        bus.step = '0;
        bus.init_phase = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_tap_p1", 32'(bus.tap_p1), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        run_line(4, 8, 128, 0, 0, 1'b0, 1'b0);
        run_line(4, 6, 192, 0, 0, 1'b0, 1'b0);
        run_line(4, 6, 256, 0, 0, 1'b0, 1'b0);
        run_line(4, 8, 128, 0, 1, 1'b0, 1'b0);
        run_line(4, 1, 128, 0, 0, 1'b0, 1'b0);
        run_line(4, 0, 128, 0, 0, 1'b0, 1'b0);
        run_line(4, 8, 128, 0, 0, 1'b1, 1'b0);
        run_line(4, 8, 128, 0, 0, 1'b0, 1'b1);
        run_line(4, 8, 128, 0, 0, 1'b0, 1'b0);
        run_line(1, 5, 77, 200, 2, 1'b0, 1'b0);
        run_line(4095, 600, 4095, 255, 0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++)
            run_line($urandom_range(1, 20), $urandom_range(0, 30), $urandom_range(16, 600),
                     $urandom_range(0, 255), 2, 1'($urandom_range(0, 1)), 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bicubic_phase_gen.md
Name: bicubic_phase_gen

Overview:
- Upstream control stage of the bicubic scaler. For each output pixel on a line it produces the fractional blend `x_blend` consumed by the bicubic weight stages (Q8 format, where 1.0 = 256).
- It also produces the four clamped source tap indices that the pixel-fetch logic uses.
- It steps a fixed-point source-position accumulator once per accepted output beat, using a valid/ready handshake.
- One run of the block covers one line, started by `start` and ending with `out_last` and `done`.

Parameters:
- IDX_W, 12, width of source/destination pixel indices and counts.
- FRAC_W, 8, fractional bits of position and step (Q8 matches coeffOne = 256).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a line; honoured only in IDLE.
- src_width  in  IDX_W  source pixels per line; must be ≥1. Sampled at start.
- dst_width  in  IDX_W  output pixels per line. Sampled at start.
- step  in  FRAC_W+4  source advance per output pixel, Q8 (128 = x2 upscale). Sampled at start.
- init_phase  in  FRAC_W  starting fractional position. Sampled at start.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  beat valid.
- x_blend  out  9  {1'b0, fraction}, range 0..255.
- tap_m1  out  IDX_W  clamp(idx-1).
- tap_0  out  IDX_W  idx.
- tap_p1  out  IDX_W  clamp(idx+1).
- tap_p2  out  IDX_W  clamp(idx+2).
- out_last  out  1  marks the final beat of the line.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the final handshake, or after an empty line.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; beat counter 0.

FSM states:
- IDLE -> RUN when start is high and dst_width ≠ 0.
- IDLE -> DONE when start is high and dst_width = 0. No beats are emitted.
- RUN -> DONE on the handshake (out_valid & out_ready) of the beat where count = dst_width-1.
- DONE -> IDLE unconditionally after one cycle; done = 1 only in DONE.
- start is ignored outside IDLE.

Latency:
- start is sampled in cycle N.
- The first beat is presented in cycle N+1, with out_valid = 1 and its outputs registered.

Accumulator:
- acc has IDX_W+FRAC_W+1 bits and is loaded with {0, init_phase} at start.
- On each handshake, acc ← acc + step, saturating at all-ones.
- The next beat is presented in the following cycle, so back-to-back beats are possible when out_ready is held high.

Outputs per beat:
- Let raw = acc >> FRAC_W and frac = acc[FRAC_W-1:0].
- If raw ≤ src_width-1: idx = raw and x_blend = frac.
- Otherwise: idx = src_width-1 and x_blend = 0 (edge clamp).
- Clamping: tap_m1 = 0 when idx = 0. tap_p1 and tap_p2 saturate at src_width-1.

Handshake:
- While out_valid = 1 and out_ready = 0, all beat outputs hold stable and acc does not advance.
- out_valid never drops without a handshake, except on reset.
- out_ready while out_valid = 0 has no effect.

Other rules:
- out_last = 1 with the beat where count = dst_width-1. A line with dst_width = 1 gives a single beat with out_last = 1.
- After the last handshake, out_valid falls in the next cycle (DONE).
- Reset asserted mid-line: immediate return to IDLE with outputs 0. The line is abandoned and no done pulse is produced.
- Inputs sampled at start are not re-read during RUN.

Test Plan:
- x2 upscale: src_width=4, dst_width=8, step=128, init_phase=0, out_ready=1.
  -> tap_0 = 0,0,1,1,2,2,3,3; x_blend = 0,128,0,128,...
  -> first beat taps (0,0,1,2); last beat taps (2,3,3,3) with out_last=1.
  -> done pulses one cycle after the 8th beat; 8 consecutive valid cycles.
- Non-integer ratio: src_width=4, dst_width=6, step=192.
  -> tap_0 = 0,0,1,2,3,3; x_blend = 0,192,128,64,0,192.
- Edge clamp: src_width=4, dst_width=6, step=256.
  -> tap_0 = 0,1,2,3,3,3; x_blend = 0 on beats 4 and 5; their taps are (2,3,3,3).
- Backpressure: x2 case with out_ready toggling 1,0,0,1,...
  -> outputs stable across stalls; exactly 8 handshakes; sequence identical to the first scenario.
- dst_width=0 -> no out_valid, done one cycle after start. start pulsed while busy -> ignored, and the sequence is unchanged.
- rst_n low after the 3rd beat -> all outputs 0 at once, no done. A fresh start afterwards reproduces the sequence from beat 0.
